multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Main control FSM for the multicycle RV32I core. It sequences the shared ALU, memory port, instruction register, PC and register file over several cycles per instruction. It drives ALUOp into the ALUControl decoder and the operand/result mux selects of the datapath. It also handles a memory-ready handshake so the core can be stalled by slow memory.

Parameters:
STATE_W, 4, width of the state register and of the debug state port.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
opcode  in  7  instr[6:0] from the instruction register.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory has completed the current access this cycle.
PCWrite  out  1  PC load enable.
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
MemWrite  out  1  memory write strobe.
IRWrite  out  1  instruction register (and OldPC) load enable.
ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALU result.
ALUSrcA  out  2  operand A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
ALUSrcB  out  2  operand B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
ALUOp  out  2  to ALUControl: 00 = add, 01 = subtract/compare, 10 = decode funct fields.
ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
RegWrite  out  1  register file write enable.
illegal_instr  out  1  one-cycle pulse when an unsupported opcode is decoded.
state  out  STATE_W  current state, for debug.

Behaviour:
- Reset: asynchronous on rst_n low. State becomes FETCH (0). While rst_n is low, PCWrite, MemWrite, IRWrite, RegWrite and illegal_instr are forced to 0. All mux selects and ALUOp are 0.
- Outputs are Moore-decoded from state, except these Mealy terms:
  - PCWrite = PCUpdate | (Branch & zero).
  - Gating by mem_ready (see FETCH and MEMWRITE below).
  - ImmSrc, decoded from opcode.
- Unlisted outputs in each state are 0.
- ImmSrc by opcode: 0000011 and 0010011 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; any other opcode -> 00.
- States and encoding:
  - FETCH = 0: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10. IRWrite and PCUpdate are asserted only when mem_ready = 1. Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
  - DECODE = 1: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (computes the branch/jump target). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> FETCH, with illegal_instr = 1 for this cycle.
  - MEMADR = 2: ALUSrcA 10, ALUSrcB 01, ALUOp 00. Goes to MEMREAD if opcode = 0000011, otherwise to MEMWRITE.
  - MEMREAD = 3: AdrSrc 1, ResultSrc 00. Holds while mem_ready = 0; goes to MEMWB when mem_ready = 1.
  - MEMWB = 4: ResultSrc 01, RegWrite 1. Goes to FETCH.
  - MEMWRITE = 5: AdrSrc 1, ResultSrc 00. MemWrite is held at 1 until mem_ready = 1. Goes to FETCH in the cycle mem_ready = 1.
  - EXECUTER = 6: ALUSrcA 10, ALUSrcB 00, ALUOp 10. Goes to ALUWB.
  - EXECUTEI = 7: ALUSrcA 10, ALUSrcB 01, ALUOp 10. Goes to ALUWB.
  - ALUWB = 8: ResultSrc 00, RegWrite 1. Goes to FETCH.
  - BEQ = 9: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch = 1. Goes to FETCH.
  - JAL = 10: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate = 1. Goes to ALUWB.
- Unused encodings 11-15 go to FETCH on the next edge with all enables 0.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles.
  - sw, R-type, I-type ALU, jal: 4 cycles.
  - beq: 3 cycles.
  - Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset mid-instruction: state returns to FETCH immediately and all enables drop in the same cycle. No partial writes complete after reset is asserted.
- At most one of RegWrite, MemWrite and IRWrite is asserted in any cycle.

Test Plan:
- Hold rst_n = 0 with mem_ready = 1 -> state = 0; IRWrite, PCWrite, MemWrite, RegWrite = 0. Release rst_n -> IRWrite = 1 and PCWrite = 1 in the first cycle.
- lw (opcode 0000011), mem_ready = 1 -> state sequence 0, 1, 2, 3, 4, 0. RegWrite = 1 with ResultSrc = 01 only in state 4. ImmSrc = 00.
- sw (opcode 0100011), mem_ready low for 2 cycles in MEMWRITE -> state sequence 0, 1, 2, 5, 5, 5, 0. MemWrite = 1 for 3 cycles. ImmSrc = 01. RegWrite never asserted.
- R-type (opcode 0110011) -> ALUOp = 10 with ALUSrcB = 00 in state 6, then state 8 with RegWrite = 1. I-type (opcode 0010011) -> state 7 with ALUSrcB = 01.
- beq (opcode 1100011): zero = 1 -> PCWrite = 1 in state 9; zero = 0 -> PCWrite = 0. Both cases have ALUOp = 01 and next state 0. jal (opcode 1101111) -> state sequence 1, 10, 8 with PCWrite = 1 in state 10 and ImmSrc = 11.
- Opcode 1111111 in DECODE -> illegal_instr pulses for 1 cycle, then FETCH. Separately, assert rst_n = 0 while in MEMWRITE -> MemWrite drops at once and state = 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode, address,
// memory, execute and writeback steps, with stalls on the memory-ready handshake.
`timescale 1ns/1ps
module multicycle_control #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [1:0]         ImmSrc,
   output logic               RegWrite,
   output logic               illegal_instr,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = STATE_W'(0),
      S_DECODE   = STATE_W'(1),
      S_MEMADR   = STATE_W'(2),
      S_MEMREAD  = STATE_W'(3),
      S_MEMWB    = STATE_W'(4),
      S_MEMWRITE = STATE_W'(5),
      S_EXECUTER = STATE_W'(6),
      S_EXECUTEI = STATE_W'(7),
      S_ALUWB    = STATE_W'(8),
      S_BEQ      = STATE_W'(9),
      S_JAL      = STATE_W'(10)
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   state_t r_state;
   state_t w_nextState;
   logic   w_pcUpdate;
   logic   w_branch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = S_FETCH;
      case (r_state)
         S_FETCH:    w_nextState = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: w_nextState = S_MEMADR;
               OP_RTYPE:          w_nextState = S_EXECUTER;
               OP_ITYPE:          w_nextState = S_EXECUTEI;
               OP_BEQ:            w_nextState = S_BEQ;
               OP_JAL:            w_nextState = S_JAL;
               default:           w_nextState = S_FETCH;
            endcase
         end
         S_MEMADR:   w_nextState = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_nextState = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    w_nextState = S_FETCH;
         S_MEMWRITE: w_nextState = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: w_nextState = S_ALUWB;
         S_EXECUTEI: w_nextState = S_ALUWB;
         S_ALUWB:    w_nextState = S_FETCH;
         S_BEQ:      w_nextState = S_FETCH;
         S_JAL:      w_nextState = S_ALUWB;
         default:    w_nextState = S_FETCH;
      endcase
   end

   // Moore decode per state, then the Mealy terms; everything is held quiet while in reset
   always_comb begin
      w_pcUpdate    = 1'b0;
      w_branch      = 1'b0;
      AdrSrc        = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALUOp         = 2'b00;
      RegWrite      = 1'b0;
      illegal_instr = 1'b0;
      case (r_state)
         S_FETCH: begin
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            IRWrite    = mem_ready;
            w_pcUpdate = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (opcode)
               OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: illegal_instr = 1'b0;
               default: illegal_instr = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA  = 2'b10;
            ALUOp    = 2'b01;
            w_branch = 1'b1;
         end
         S_JAL: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            w_pcUpdate = 1'b1;
         end
         default: begin
            w_pcUpdate = 1'b0;
         end
      endcase

      case (opcode)
         OP_STORE: ImmSrc = 2'b01;
         OP_BEQ:   ImmSrc = 2'b10;
         OP_JAL:   ImmSrc = 2'b11;
         default:  ImmSrc = 2'b00;
      endcase

      PCWrite = w_pcUpdate | (w_branch & zero);

      if (!rst_n) begin
         PCWrite       = 1'b0;
         AdrSrc        = 1'b0;
         MemWrite      = 1'b0;
         IRWrite       = 1'b0;
         ResultSrc     = 2'b00;
         ALUSrcA       = 2'b00;
         ALUSrcB       = 2'b00;
         ALUOp         = 2'b00;
         ImmSrc        = 2'b00;
         RegWrite      = 1'b0;
         illegal_instr = 1'b0;
      end
   end

   assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its
// state sequence and compares the control outputs with hand-derived values.
`timescale 1ns/1ps
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
   logic [3:0] state;

   int nChecks = 0;
   int nPass   = 0;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   multicycle_control #(.STATE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal_instr(illegal_instr), .state(state)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual === expected) nPass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
   endtask

   // Inputs change 2ns after the edge and outputs are read 1ns later, away from the edge
   task automatic applyStimulus(input logic [6:0] op, input logic rdy, input logic z);
      opcode    = op;
      mem_ready = rdy;
      zero      = z;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(7'b0, 1'b1, 1'b0);
      #12;
      checkOutput("rst_state",    state, 0);
      checkOutput("rst_irwrite",  IRWrite, 0);
      checkOutput("rst_pcwrite",  PCWrite, 0);
      checkOutput("rst_memwrite", MemWrite, 0);
      checkOutput("rst_regwrite", RegWrite, 0);
      checkOutput("rst_alusrcb",  ALUSrcB, 0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("fetch_irwrite", IRWrite, 1);
      checkOutput("fetch_pcwrite", PCWrite, 1);
      checkOutput("fetch_alusrcb", ALUSrcB, 2);
      checkOutput("fetch_result",  ResultSrc, 2);

      // lw
      applyStimulus(OP_LOAD, 1'b1, 1'b0);
      checkOutput("lw_imm", ImmSrc, 0);
      nextCycle(); applyStimulus(OP_LOAD, 1'b1, 1'b0);
      checkOutput("lw_s1", state, 1);
      checkOutput("lw_dec_srca", ALUSrcA, 1);
      checkOutput("lw_dec_srcb", ALUSrcB, 1);
      nextCycle(); applyStimulus(OP_LOAD, 1'b1, 1'b0);
      checkOutput("lw_s2", state, 2);
      checkOutput("lw_adr_srca", ALUSrcA, 2);
      nextCycle(); applyStimulus(OP_LOAD, 1'b1, 1'b0);
      checkOutput("lw_s3", state, 3);
      checkOutput("lw_rd_adrsrc", AdrSrc, 1);
      checkOutput("lw_rd_regwrite", RegWrite, 0);
      nextCycle(); applyStimulus(OP_LOAD, 1'b1, 1'b0);
      checkOutput("lw_s4", state, 4);
      checkOutput("lw_wb_regwrite", RegWrite, 1);
      checkOutput("lw_wb_result", ResultSrc, 1);
      nextCycle(); applyStimulus(OP_LOAD, 1'b0, 1'b0);
      checkOutput("lw_s0", state, 0);

      // fetch stall
      checkOutput("stall_irwrite", IRWrite, 0);
      checkOutput("stall_pcwrite", PCWrite, 0);
      nextCycle(); applyStimulus(OP_STORE, 1'b1, 1'b0);
      checkOutput("stall_state", state, 0);
      checkOutput("sw_imm", ImmSrc, 1);

      // sw with two not-ready cycles in MEMWRITE
      nextCycle(); applyStimulus(OP_STORE, 1'b1, 1'b0);
      checkOutput("sw_s1", state, 1);
      nextCycle(); applyStimulus(OP_STORE, 1'b1, 1'b0);
      checkOutput("sw_s2", state, 2);
      for (int i = 0; i < 3; i++) begin
         nextCycle(); applyStimulus(OP_STORE, (i == 2), 1'b0);
         checkOutput($sformatf("sw_s5_%0d", i), state, 5);
         checkOutput($sformatf("sw_memwrite_%0d", i), MemWrite, 1);
         checkOutput($sformatf("sw_regwrite_%0d", i), RegWrite, 0);
      end
      nextCycle(); applyStimulus(OP_RTYPE, 1'b1, 1'b0);
      checkOutput("sw_s0", state, 0);
      checkOutput("sw_memwrite_off", MemWrite, 0);

      // R-type
      nextCycle(); applyStimulus(OP_RTYPE, 1'b1, 1'b0);
      nextCycle(); applyStimulus(OP_RTYPE, 1'b1, 1'b0);
      checkOutput("r_s6", state, 6);
      checkOutput("r_aluop", ALUOp, 2);
      checkOutput("r_srcb", ALUSrcB, 0);
      nextCycle(); applyStimulus(OP_RTYPE, 1'b1, 1'b0);
      checkOutput("r_s8", state, 8);
      checkOutput("r_regwrite", RegWrite, 1);
      nextCycle(); applyStimulus(OP_ITYPE, 1'b1, 1'b0);
      checkOutput("r_s0", state, 0);

      // I-type
      nextCycle(); applyStimulus(OP_ITYPE, 1'b1, 1'b0);
      nextCycle(); applyStimulus(OP_ITYPE, 1'b1, 1'b0);
      checkOutput("i_s7", state, 7);
      checkOutput("i_srcb", ALUSrcB, 1);
      checkOutput("i_aluop", ALUOp, 2);
      nextCycle(); applyStimulus(OP_BEQ, 1'b1, 1'b0);
      checkOutput("i_s8", state, 8);
      nextCycle(); applyStimulus(OP_BEQ, 1'b1, 1'b0);

      // beq, taken then not taken within the same BEQ cycle
      nextCycle(); applyStimulus(OP_BEQ, 1'b1, 1'b0);
      checkOutput("beq_s1", state, 1);
      nextCycle(); applyStimulus(OP_BEQ, 1'b1, 1'b1);
      checkOutput("beq_s9", state, 9);
      checkOutput("beq_taken", PCWrite, 1);
      checkOutput("beq_aluop", ALUOp, 1);
      checkOutput("beq_imm", ImmSrc, 2);
      applyStimulus(OP_BEQ, 1'b1, 1'b0);
      checkOutput("beq_not_taken", PCWrite, 0);
      nextCycle(); applyStimulus(OP_JAL, 1'b1, 1'b0);
      checkOutput("beq_s0", state, 0);

      // jal
      nextCycle(); applyStimulus(OP_JAL, 1'b1, 1'b0);
      checkOutput("jal_s1", state, 1);
      nextCycle(); applyStimulus(OP_JAL, 1'b1, 1'b0);
      checkOutput("jal_s10", state, 10);
      checkOutput("jal_pcwrite", PCWrite, 1);
      checkOutput("jal_imm", ImmSrc, 3);
      checkOutput("jal_srcb", ALUSrcB, 2);
      nextCycle(); applyStimulus(OP_BAD, 1'b1, 1'b0);
      checkOutput("jal_s8", state, 8);
      nextCycle(); applyStimulus(OP_BAD, 1'b1, 1'b0);

      // illegal opcode
      nextCycle(); applyStimulus(OP_BAD, 1'b1, 1'b0);
      checkOutput("ill_s1", state, 1);
      checkOutput("ill_pulse", illegal_instr, 1);
      nextCycle(); applyStimulus(OP_STORE, 1'b1, 1'b0);
      checkOutput("ill_s0", state, 0);
      checkOutput("ill_clear", illegal_instr, 0);

      // reset asserted while in MEMWRITE
      nextCycle(); applyStimulus(OP_STORE, 1'b1, 1'b0);
      nextCycle(); applyStimulus(OP_STORE, 1'b0, 1'b0);
      nextCycle(); applyStimulus(OP_STORE, 1'b0, 1'b0);
      checkOutput("rstmw_s5", state, 5);
      checkOutput("rstmw_memwrite_on", MemWrite, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rstmw_memwrite_off", MemWrite, 0);
      checkOutput("rstmw_state", state, 0);
      nextCycle();
      checkOutput("rstmw_held", state, 0);

      $display("[TB] %0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
